// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and defaults for the IF/MEM SRAM arbiter.
package arm_mem_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} mem_state_t;
    typedef enum logic {GNT_IF, GNT_MEM} mem_gnt_t;
    localparam int WAIT_CYCLES_DEF = 5;
endpackage

// File: rtl/arm_mem_wait_cnt.sv
// arm_mem_wait_cnt: loadable down-counter timing one SRAM access, with zero flag.
module arm_mem_wait_cnt
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    localparam int W = $clog2(WAIT_CYCLES + 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= W'(WAIT_CYCLES - 1);
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/arm_mem_arbiter.sv
// arm_mem_arbiter: round-robin sharing of one multi-cycle SRAM between IF fetches
// and MEM loads/stores, with a one-cycle ready pulse per completed access.
module arm_mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 16,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_if_req,
    input  logic [ADDR_W-1:0]      i_if_addr,
    output logic [DATA_W-1:0]      o_if_rdata,
    output logic                   o_if_ready,
    input  logic                   i_mem_rd_req,
    input  logic                   i_mem_wr_req,
    input  logic [ADDR_W-1:0]      i_mem_addr,
    input  logic [DATA_W-1:0]      i_mem_wdata,
    output logic [DATA_W-1:0]      o_mem_rdata,
    output logic                   o_mem_ready,
    output logic                   o_sram_cs,
    output logic                   o_sram_we,
    output logic [SRAM_ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0]      o_sram_wdata,
    input  logic [DATA_W-1:0]      i_sram_rdata,
    output logic                   o_busy
);
    mem_state_t r_state, w_next;
    mem_gnt_t r_gnt, r_last;
    logic r_we;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_if_rdata, r_mem_rdata;
    logic w_mem_pend, w_gnt_mem, w_grant, w_access, w_zero, w_cap, w_unused;
    assign w_mem_pend = i_mem_rd_req | i_mem_wr_req;
    // Contested requests go to whichever side was not served last.
    assign w_gnt_mem  = w_mem_pend && (!i_if_req || r_last == GNT_IF);
    assign w_grant    = (r_state == ST_IDLE) && (i_if_req || w_mem_pend);
    assign w_access   = (r_state == ST_ACCESS);
    assign w_cap      = w_access && w_zero && !r_we;
    assign w_unused   = ^{i_if_addr[ADDR_W-1:SRAM_ADDR_W+2], i_if_addr[1:0],
                          i_mem_addr[ADDR_W-1:SRAM_ADDR_W+2], i_mem_addr[1:0]};
    arm_mem_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_grant),
        .i_dec   (w_access),
        .o_zero  (w_zero)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = w_grant ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: w_next = w_zero ? ST_DONE : ST_ACCESS;
            default:   w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt       <= GNT_IF;
            r_last      <= GNT_IF;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_gnt   <= w_gnt_mem ? GNT_MEM : GNT_IF;
                r_last  <= w_gnt_mem ? GNT_MEM : GNT_IF;
                r_we    <= w_gnt_mem && i_mem_wr_req;
                r_addr  <= w_gnt_mem ? i_mem_addr[SRAM_ADDR_W+1:2] : i_if_addr[SRAM_ADDR_W+1:2];
                r_wdata <= i_mem_wdata;
            end
            if (w_cap && r_gnt == GNT_IF) r_if_rdata <= i_sram_rdata;
            if (w_cap && r_gnt == GNT_MEM) r_mem_rdata <= i_sram_rdata;
        end
    end
    assign o_sram_cs    = w_access;
    assign o_sram_we    = w_access && r_we;
    assign o_sram_addr  = r_addr;
    assign o_sram_wdata = r_wdata;
    assign o_if_rdata   = r_if_rdata;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_if_ready   = (r_state == ST_DONE) && (r_gnt == GNT_IF);
    assign o_mem_ready  = (r_state == ST_DONE) && (r_gnt == GNT_MEM);
    assign o_busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_arm_mem_arbiter.sv
// tb_arm_mem_arbiter: directed cycle-accurate checks of the IF/MEM SRAM arbiter
// with WAIT_CYCLES=5.
module tb_arm_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, mem_rd_req, mem_wr_req;
    logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
    logic [31:0] if_rdata, mem_rdata, sram_wdata;
    logic        if_ready, mem_ready, sram_cs, sram_we, busy;
    logic [15:0] sram_addr;
    logic [31:0] e_if, e_mem;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    arm_mem_arbiter #(.WAIT_CYCLES(5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .o_if_rdata   (if_rdata),
        .o_if_ready   (if_ready),
        .i_mem_rd_req (mem_rd_req),
        .i_mem_wr_req (mem_wr_req),
        .i_mem_addr   (mem_addr),
        .i_mem_wdata  (mem_wdata),
        .o_mem_rdata  (mem_rdata),
        .o_mem_ready  (mem_ready),
        .o_sram_cs    (sram_cs),
        .o_sram_we    (sram_we),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata),
        .o_busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge whose following posedge samples the grant; returns at the ready cycle.
    task automatic xfer(input bit m, input logic [15:0] a, input bit we, input logic [31:0] wd);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("cs", {31'd0, sram_cs}, 32'd1);
            check("we", {31'd0, sram_we}, {31'd0, we});
            check("addr", {16'd0, sram_addr}, {16'd0, a});
            check("busy", {31'd0, busy}, 32'd1);
            check("rdy_early", {30'd0, if_ready, mem_ready}, 32'd0);
            if (we) check("wdata", sram_wdata, wd);
        end
        @(negedge clk);
        check("if_ready", {31'd0, if_ready}, {31'd0, !m});
        check("mem_ready", {31'd0, mem_ready}, {31'd0, m});
        check("cs_done", {31'd0, sram_cs}, 32'd0);
        check("if_rdata", if_rdata, e_if);
        check("mem_rdata", mem_rdata, e_mem);
    endtask

    initial begin
        rst_n = 1'b0;
        {if_req, mem_rd_req, mem_wr_req} = 3'b000;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
        e_if = '0; e_mem = '0;
        repeat (2) @(negedge clk);
        check("rst_cs", {31'd0, sram_cs}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy", {30'd0, if_ready, mem_ready}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_addr", {16'd0, sram_addr}, 32'd0);
        rst_n = 1'b1;

        // IF-only fetch
        if_req = 1'b1; if_addr = 32'h0000_0010; sram_rdata = 32'hE3A0_0001; e_if = 32'hE3A0_0001;
        xfer(1'b0, 16'h0004, 1'b0, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_rdy_once", {31'd0, if_ready}, 32'd0);

        // MEM store: read data must not be captured
        mem_wr_req = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hDEAD_BEEF; sram_rdata = 32'hCAFE_0000;
        xfer(1'b1, 16'h0100, 1'b1, 32'hDEAD_BEEF);
        mem_wr_req = 1'b0;
        @(negedge clk);
        check("t2_mem_rdata", mem_rdata, 32'd0);
        check("t2_rdy_once", {31'd0, mem_ready}, 32'd0);

        // Contested after reset: MEM, IF, MEM, IF with ready 7 cycles apart
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e_if = '0; e_mem = '0;
        if_req = 1'b1; if_addr = 32'h20; mem_rd_req = 1'b1; mem_addr = 32'h104;
        for (int k = 0; k < 4; k++) begin
            sram_rdata = 32'h1111_1111 * (k + 1);
            if (k % 2 == 0) e_mem = sram_rdata; else e_if = sram_rdata;
            xfer(k % 2 == 0, (k % 2 == 0) ? 16'h0041 : 16'h0008, 1'b0, 32'd0);
            if (k == 3) {if_req, mem_rd_req} = 2'b00;
            @(negedge clk);
            check("rr_gap", {31'd0, busy}, 32'd0);
        end

        // Read and write together behave as a store
        mem_rd_req = 1'b1; mem_wr_req = 1'b1; mem_addr = 32'h800; mem_wdata = 32'h1234_5678;
        sram_rdata = 32'hAAAA_5555;
        xfer(1'b1, 16'h0200, 1'b1, 32'h1234_5678);
        {mem_rd_req, mem_wr_req} = 2'b00;
        @(negedge clk);
        check("t6_mem_rdata", mem_rdata, 32'h3333_3333);

        // Reset mid-access aborts with no ready, then IF restarts from scratch
        rst_n = 1'b0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; mem_wr_req = 1'b1; mem_addr = 32'hC; mem_wdata = 32'h55;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_we_before", {31'd0, sram_we}, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_cs_async", {31'd0, sram_cs}, 32'd0);
        check("t5_we_async", {31'd0, sram_we}, 32'd0);
        check("t5_busy_async", {31'd0, busy}, 32'd0);
        check("t5_no_rdy", {30'd0, if_ready, mem_ready}, 32'd0);
        mem_wr_req = 1'b0;
        e_if = '0; e_mem = '0;
        @(negedge clk);
        check("t5_rdata_clr", mem_rdata, 32'd0);
        rst_n = 1'b1;
        sram_rdata = 32'h0BAD_F00D; e_if = 32'h0BAD_F00D;
        xfer(1'b0, 16'h0010, 1'b0, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        check("t5_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
